// File: rtl/gray_code_arbiter.sv
// gray_code_arbiter: one shared binary/Gray conversion datapath serving two
// requesters through a round-robin arbiter. The binary-to-Gray conversion
// takes a single cycle. The Gray-to-binary conversion is bit-serial, MSB first.
// All outputs are registered, so there is no combinational path from the
// req or din inputs to any output.
module gray_code_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             mode0,
  input  logic [WIDTH-1:0] din0,
  input  logic             req1,
  input  logic             mode1,
  input  logic [WIDTH-1:0] din1,
  output logic             ack0,
  output logic             ack1,
  output logic             done,
  output logic             owner,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_d;          // operand latched at grant
  logic             r_mode;       // operation latched at grant
  logic             r_last_grant; // requester granted most recently
  logic [IDX_W-1:0] r_idx;        // current bit of the serial Gray-to-binary op
  logic             r_bit;        // previously decoded binary bit (b[i+1])
  logic [WIDTH-1:0] r_acc;        // partially decoded binary value

  logic             w_any;
  logic             w_winner;
  logic [WIDTH-1:0] w_din;
  logic             w_mode;
  logic [WIDTH-1:0] w_gray;
  logic             w_bin_bit;
  logic [WIDTH-1:0] w_acc_next;

  // Round-robin pick: when both requesters ask, grant the one not served last.
  // When only one asks, grant that one.
  always_comb begin
    w_any    = req0 | req1;
    w_winner = req1;
    if (req0 && req1) begin
      w_winner = ~r_last_grant;
    end
    w_din  = w_winner ? din1 : din0;
    w_mode = w_winner ? mode1 : mode0;
  end

  // Binary-to-Gray conversion: each bit XORs with its upper neighbour, and the MSB passes through.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_b2g
      assign w_gray[gi] = r_d[gi] ^ r_d[gi+1];
    end
  endgenerate
  assign w_gray[WIDTH-1] = r_d[WIDTH-1];

  // One Gray-to-binary step: b[i] = b[i+1] ^ g[i]. r_bit starts at 0, so the MSB step yields g[MSB].
  always_comb begin
    w_bin_bit         = r_bit ^ r_d[r_idx];
    w_acc_next        = r_acc;
    w_acc_next[r_idx] = w_bin_bit;
  end

  // Control FSM with registered outputs. dout changes only when a result completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_d          <= '0;
      r_mode       <= 1'b0;
      r_last_grant <= 1'b1;
      r_idx        <= '0;
      r_bit        <= 1'b0;
      r_acc        <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      done         <= 1'b0;
      owner        <= 1'b0;
      dout         <= '0;
      busy         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state      <= S_CONV;
            busy         <= 1'b1;
            owner        <= w_winner;
            r_last_grant <= w_winner;
            r_d          <= w_din;
            r_mode       <= w_mode;
            r_idx        <= IDX_W'(WIDTH - 1);
            r_bit        <= 1'b0;
            r_acc        <= '0;
          end
        end
        S_CONV: begin
          if (!r_mode) begin
            dout    <= w_gray;
            done    <= 1'b1;
            ack0    <= ~owner;
            ack1    <= owner;
            r_state <= S_DONE;
          end else begin
            r_acc <= w_acc_next;
            r_bit <= w_bin_bit;
            if (r_idx == '0) begin
              dout    <= w_acc_next;
              done    <= 1'b1;
              ack0    <= ~owner;
              ack1    <= owner;
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx - 1'b1;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
